s3g_tx_arb: RTL
===============

Name: s3g_tx_arb

Overview:
- Shares the single s3g_tx packet transmitter between two packet sources.
  - Requester 0: executor command replies.
  - Requester 1: asynchronous status/event reporter.
- Each requester gets a one-entry holding slot.
- A round-robin scheduler issues held packets to s3g_tx one at a time, then tracks tx_busy until the packet has left.
- Sits between the requesters and s3g_tx; drives s3g_tx's packet_wr, payload_len and buffer inputs.

Parameters:
- MAX_LEN, 16, largest payload length accepted (buffer depth in bytes).
- BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after tx_packet_wr before abandoning the packet.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low: rst=0 at a rising edge resets the block.
- req0_wr  in  1  one-cycle request-0 packet write strobe.
- req0_len  in  8  request-0 payload length.
- req0_buf  in  128  request-0 payload; byte k on bits [8k+7:8k].
- req0_busy  out  1  slot 0 occupied (pending or in flight).
- req0_err  out  1  one-cycle pulse: request-0 write rejected.
- req1_wr, req1_len, req1_buf, req1_busy, req1_err  as above for requester 1.
- tx_busy  in  1  s3g_tx busy.
- tx_packet_wr  out  1  one-cycle packet strobe to s3g_tx.
- tx_payload_len  out  8  length of granted packet.
- tx_buf  out  128  payload of granted packet, same byte packing.
- tx_src  out  1  requester owning the current/last grant.
- timeout_cnt  out  8  count of BUSY_TIMEOUT events, saturating at 255.

Behaviour:
Reset:
- Every output is 0: req*_busy, req*_err, tx_packet_wr, tx_payload_len, tx_buf, tx_src, timeout_cnt.
- State is IDLE, both slots are empty, last_grant=1 (so requester 0 wins the first tie), and the timeout counter is 0.
- Reset mid-transfer abandons all held packets; s3g_tx shares the same rst.

Slot capture:
- A write is accepted when reqN_wr=1, reqN_busy=0 and reqN_len<=MAX_LEN.
- Len and buf are latched at that edge; reqN_busy=1 from the next cycle.
- reqN_len=0 is valid (empty payload).
- Rejected write (reqN_busy=1 or len>MAX_LEN): nothing is latched, and reqN_err pulses high for exactly one cycle, the cycle after the write.
- Slots are independent; both may be written in the same cycle.

Scheduler FSM (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE):
- IDLE: if tx_busy=0 and at least one slot is full, grant and go to ISSUE.
  - One slot full: grant it.
  - Both full: grant the slot != last_grant.
  - tx_payload_len, tx_buf and tx_src are loaded from the granted slot at the grant edge and held stable until the next grant.
- ISSUE: tx_packet_wr=1 for this single cycle; go to WAIT_BUSY with the wait counter cleared.
- WAIT_BUSY, tx_busy=1: go to WAIT_DONE.
- WAIT_BUSY, tx_busy=0: counter increments; when it reaches BUSY_TIMEOUT, the packet is abandoned.
  - timeout_cnt increments (saturating).
  - The slot is freed and last_grant=tx_src.
  - Go to IDLE.
- WAIT_DONE, tx_busy=0: free the slot (reqN_busy=0 next cycle), last_grant=tx_src, go to IDLE.

Latency:
- reqN_wr high in cycle k with TX idle gives tx_packet_wr high in cycle k+2.
- A slot freed at edge e can be re-granted at the earliest at edge e+1.

Boundaries:
- A write arriving in the same cycle its slot is being freed is rejected with err, because busy is still 1 that cycle.
- A new slot fill during WAIT_* waits for IDLE; no preemption.
- tx_packet_wr never asserts while tx_busy=1 was seen in the granting IDLE cycle.
- Fairness: with both requesters continuously refilling, grants strictly alternate.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 for 3 cycles with req0_wr=1.
  - Required: all outputs 0, no latch; after release, req0_busy=0.
- Single packet:
  - Stimulus: req0 write len=3, bytes 01 02 03, TX idle; model raises tx_busy 1 cycle after tx_packet_wr and holds it 20 cycles.
  - Required: tx_packet_wr one cycle at k+2 with tx_payload_len=3, tx_buf[23:0]=030201, tx_src=0; req0_busy falls 1 cycle after tx_busy falls.
- Tie, round-robin:
  - Stimulus: req0 and req1 written in the same cycle (len 4, len 2), then both refilled twice more.
  - Required: grant order 0,1,0,1,0,1 and exactly one tx_packet_wr per packet.
- Rejects:
  - Stimulus: req1 write len=17; then a valid req1 write followed by a second req1 write while req1_busy=1.
  - Required: req1_err pulses one cycle for each rejected write; the held packet is unchanged and sent once.
- Timeout:
  - Stimulus: TX model never raises tx_busy.
  - Required: after BUSY_TIMEOUT=4 cycles in WAIT_BUSY, timeout_cnt=1, slot freed, FSM back in IDLE; 256 timeouts leave timeout_cnt=255.
- TX busy at grant time:
  - Stimulus: tx_busy held high externally while req0 is full.
  - Required: no tx_packet_wr until tx_busy=0, then one strobe.

Source files
------------

// File: rtl/s3g_tx_arb.sv
// Two-requester round-robin front end for the s3g_tx packet transmitter.
// Each requester owns a one-entry slot; the scheduler issues one packet at a time and tracks tx_busy.
//
// state     | meaning
// IDLE      | waiting for a full slot while the transmitter is free
// ISSUE     | one-cycle tx_packet_wr strobe for the granted slot
// WAIT_BUSY | waiting for tx_busy to rise, bounded by BUSY_TIMEOUT
// WAIT_DONE | packet in flight, waiting for tx_busy to fall
module s3g_tx_arb #(
  parameter int MAX_LEN      = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_wr,
  input  logic [7:0]           req0_len,
  input  logic [MAX_LEN*8-1:0] req0_buf,
  output logic                 req0_busy,
  output logic                 req0_err,
  input  logic                 req1_wr,
  input  logic [7:0]           req1_len,
  input  logic [MAX_LEN*8-1:0] req1_buf,
  output logic                 req1_busy,
  output logic                 req1_err,
  input  logic                 tx_busy,
  output logic                 tx_packet_wr,
  output logic [7:0]           tx_payload_len,
  output logic [MAX_LEN*8-1:0] tx_buf,
  output logic                 tx_src,
  output logic [7:0]           timeout_cnt
);

  localparam int BW = MAX_LEN * 8;
  localparam logic [7:0] LEN_MAX   = 8'(MAX_LEN);
  localparam logic [7:0] WAIT_LAST = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t state, state_n;

  logic [1:0]    wr_v;
  logic [7:0]    len_v    [2];
  logic [BW-1:0] buf_v    [2];
  logic [1:0]    slot_full;
  logic [1:0]    slot_err;
  logic [7:0]    slot_len [2];
  logic [BW-1:0] slot_buf [2];
  logic [1:0]    accept;
  logic [1:0]    reject;
  logic [1:0]    free_v;
  logic          last_grant;
  logic [7:0]    wait_cnt;
  logic          grant_en;
  logic          grant_sel;
  logic          free_en;
  logic          timeout_ev;
  logic          wait_clr;
  logic          wait_inc;

  assign wr_v     = {req1_wr, req0_wr};
  assign len_v[0] = req0_len;
  assign len_v[1] = req1_len;
  assign buf_v[0] = req0_buf;
  assign buf_v[1] = req1_buf;

  assign req0_busy = slot_full[0];
  assign req1_busy = slot_full[1];
  assign req0_err  = slot_err[0];
  assign req1_err  = slot_err[1];

  // Accept and free never coincide on one slot: accept needs it empty, free needs it full.
  always_comb begin
    accept = '0;
    reject = '0;
    free_v = '0;
    for (int i = 0; i < 2; i++) begin
      accept[i] = wr_v[i] && !slot_full[i] && (len_v[i] <= LEN_MAX);
      reject[i] = wr_v[i] && !accept[i];
      free_v[i] = free_en && (tx_src == 1'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_full <= '0;
      slot_err  <= '0;
      for (int i = 0; i < 2; i++) begin
        slot_len[i] <= '0;
        slot_buf[i] <= '0;
      end
    end else begin
      slot_err <= reject;
      for (int i = 0; i < 2; i++) begin
        if (accept[i]) begin
          slot_full[i] <= 1'b1;
          slot_len[i]  <= len_v[i];
          slot_buf[i]  <= buf_v[i];
        end else if (free_v[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_n      = state;
    grant_en     = 1'b0;
    grant_sel    = 1'b0;
    free_en      = 1'b0;
    timeout_ev   = 1'b0;
    wait_clr     = 1'b0;
    wait_inc     = 1'b0;
    tx_packet_wr = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && (slot_full != 2'b00)) begin
          grant_en  = 1'b1;
          grant_sel = (slot_full == 2'b11) ? !last_grant : slot_full[1];
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        tx_packet_wr = 1'b1;
        wait_clr     = 1'b1;
        state_n      = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_ev = 1'b1;
          free_en    = 1'b1;
          state_n    = IDLE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          free_en = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      wait_cnt       <= '0;
      tx_payload_len <= '0;
      tx_buf         <= '0;
      tx_src         <= 1'b0;
      timeout_cnt    <= '0;
    end else begin
      state <= state_n;
      if (grant_en) begin
        tx_payload_len <= slot_len[grant_sel];
        tx_buf         <= slot_buf[grant_sel];
        tx_src         <= grant_sel;
      end
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (free_en) begin
        last_grant <= tx_src;
      end
      if (timeout_ev && (timeout_cnt != 8'hFF)) begin
        timeout_cnt <= timeout_cnt + 8'd1;
      end
    end
  end

endmodule
